// File: rtl/axi_single_beat_master_pkg.sv
// Shared AXI encodings, FSM state type and size helper for the single-beat master.
package axi_single_beat_master_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } state_e;

  function automatic logic [2:0] axi_size(input int unsigned data_width);
    return 3'($clog2(data_width / 8));
  endfunction

endpackage

// File: rtl/axi_channel.sv
// AXI4 channel bundle with master/slave views.
interface axi_channel #(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     aw_id;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic                    aw_lock;
  logic [3:0]              aw_cache;
  logic [2:0]              aw_prot;
  logic [3:0]              aw_region;
  logic [3:0]              aw_qos;
  logic [USER_WIDTH-1:0]   aw_user;
  logic                    aw_valid;
  logic                    aw_ready;

  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    w_last;
  logic [USER_WIDTH-1:0]   w_user;
  logic                    w_valid;
  logic                    w_ready;

  logic [ID_WIDTH-1:0]     b_id;
  logic [1:0]              b_resp;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    b_valid;
  logic                    b_ready;

  logic [ID_WIDTH-1:0]     ar_id;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic                    ar_lock;
  logic [3:0]              ar_cache;
  logic [2:0]              ar_prot;
  logic [3:0]              ar_region;
  logic [3:0]              ar_qos;
  logic [USER_WIDTH-1:0]   ar_user;
  logic                    ar_valid;
  logic                    ar_ready;

  logic [ID_WIDTH-1:0]     r_id;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic                    r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_single_beat_master.sv
// Turns a simple request/response port into single-beat AXI4 transactions,
// one outstanding at a time.
module axi_single_beat_master
  import axi_single_beat_master_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned TXN_ID     = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  axi_channel.master              outgoing_openip
);

  localparam logic [2:0]          SIZE_ENC = axi_size(DATA_WIDTH);
  localparam logic [ID_WIDTH-1:0] ID_VAL   = ID_WIDTH'(TXN_ID);

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    err_q;
  logic                    aw_done_q, w_done_q, r_first_q;

  logic aw_vld, w_vld, ar_vld, b_rdy, r_rdy;
  logic req_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic b_bad, r_bad;
  logic unused_user;

  assign req_hs = req_valid & req_ready;
  assign aw_hs  = aw_vld & outgoing_openip.aw_ready;
  assign w_hs   = w_vld  & outgoing_openip.w_ready;
  assign b_hs   = b_rdy  & outgoing_openip.b_valid;
  assign ar_hs  = ar_vld & outgoing_openip.ar_ready;
  assign r_hs   = r_rdy  & outgoing_openip.r_valid;

  assign b_bad = (outgoing_openip.b_resp == RESP_SLVERR) || (outgoing_openip.b_resp == RESP_DECERR) ||
                 (outgoing_openip.b_id != ID_VAL);
  assign r_bad = (outgoing_openip.r_resp == RESP_SLVERR) || (outgoing_openip.r_resp == RESP_DECERR) ||
                 (outgoing_openip.r_id != ID_VAL);

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_hs) state_d = req_we ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) state_d = WR_RESP;
      WR_RESP: if (b_hs) state_d = RSP;
      RD_REQ:  if (ar_hs) state_d = RD_DATA;
      RD_DATA: if (r_hs && outgoing_openip.r_last) state_d = RSP;
      RSP:     if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by rstn so it stays low while reset is held.
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    aw_vld    = 1'b0;
    w_vld     = 1'b0;
    ar_vld    = 1'b0;
    b_rdy     = 1'b0;
    r_rdy     = 1'b0;
    unique case (state_q)
      IDLE:    req_ready = rstn;
      WR_REQ: begin
        aw_vld = ~aw_done_q;
        w_vld  = ~w_done_q;
      end
      WR_RESP: b_rdy     = 1'b1;
      RD_REQ:  ar_vld    = 1'b1;
      RD_DATA: r_rdy     = 1'b1;
      RSP:     rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Only the first R beat carries data; a missing r_last on it flags the error,
  // and the remaining beats are drained without touching the captured result.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      r_first_q <= 1'b0;
    end else begin
      if (req_hs) begin
        addr_q    <= req_addr;
        wdata_q   <= req_wdata;
        wstrb_q   <= req_wstrb;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        r_first_q <= 1'b1;
      end
      if (aw_hs) aw_done_q <= 1'b1;
      if (w_hs)  w_done_q  <= 1'b1;
      if (b_hs) begin
        rdata_q <= '0;
        err_q   <= b_bad;
      end
      if (r_hs && r_first_q) begin
        rdata_q   <= outgoing_openip.r_data;
        err_q     <= r_bad | ~outgoing_openip.r_last;
        r_first_q <= 1'b0;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  assign outgoing_openip.aw_id     = ID_VAL;
  assign outgoing_openip.aw_addr   = addr_q;
  assign outgoing_openip.aw_len    = '0;
  assign outgoing_openip.aw_size   = SIZE_ENC;
  assign outgoing_openip.aw_burst  = BURST_INCR;
  assign outgoing_openip.aw_lock   = 1'b0;
  assign outgoing_openip.aw_cache  = '0;
  assign outgoing_openip.aw_prot   = '0;
  assign outgoing_openip.aw_region = '0;
  assign outgoing_openip.aw_qos    = '0;
  assign outgoing_openip.aw_user   = '0;
  assign outgoing_openip.aw_valid  = aw_vld;

  assign outgoing_openip.w_data    = wdata_q;
  assign outgoing_openip.w_strb    = wstrb_q;
  assign outgoing_openip.w_last    = 1'b1;
  assign outgoing_openip.w_user    = '0;
  assign outgoing_openip.w_valid   = w_vld;

  assign outgoing_openip.b_ready   = b_rdy;

  assign outgoing_openip.ar_id     = ID_VAL;
  assign outgoing_openip.ar_addr   = addr_q;
  assign outgoing_openip.ar_len    = '0;
  assign outgoing_openip.ar_size   = SIZE_ENC;
  assign outgoing_openip.ar_burst  = BURST_INCR;
  assign outgoing_openip.ar_lock   = 1'b0;
  assign outgoing_openip.ar_cache  = '0;
  assign outgoing_openip.ar_prot   = '0;
  assign outgoing_openip.ar_region = '0;
  assign outgoing_openip.ar_qos    = '0;
  assign outgoing_openip.ar_user   = '0;
  assign outgoing_openip.ar_valid  = ar_vld;

  assign outgoing_openip.r_ready   = r_rdy;

  assign unused_user = ^{outgoing_openip.b_user, outgoing_openip.r_user};

endmodule

// File: tb/tb_axi_single_beat_master.sv
// Directed and randomized bench for axi_single_beat_master with a behavioural slave.
module tb_axi_single_beat_master;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned USER_W = 1;
  localparam int unsigned TXN    = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_valid, req_ready, req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [7:0]        req_wstrb;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] beat_data [4];

  always #5 clk = ~clk;

  axi_channel #(.ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .USER_WIDTH(USER_W)) axi ();

  axi_single_beat_master #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(ADDR_W), .DATA_WIDTH(DATA_W), .USER_WIDTH(USER_W), .TXN_ID(TXN)
  ) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .outgoing_openip(axi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
    axi.r_valid = 1'b0; axi.r_resp = 2'b00; axi.r_id = '0; axi.r_user = '0;
    axi.r_data = '0; axi.r_last = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws);
    int  waited;
    bit  acc;
    waited = 0;
    acc = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_wstrb = ws;
    for (int i = 0; i < 20; i++) begin
      if (req_ready === 1'b1) begin
        acc = 1'b1;
        tick();
        break;
      end
      waited++;
      tick();
    end
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = {$urandom, $urandom};
    req_wstrb = 8'($urandom);
    check("req_accept", 64'(acc), 64'd1);
    check("req_wait", 64'(waited), 64'd0);
  endtask

  // rsp_dly < 0 means rsp_ready was already high before the response appeared.
  task automatic finish_rsp(input int k, input int exp_k, input logic [63:0] exp_rdata,
                            input logic exp_err, input int rsp_dly);
    check("rsp_latency", 64'(k), 64'(exp_k));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    check("rsp_err", 64'(rsp_err), 64'(exp_err));
    check("req_ready_in_rsp", 64'(req_ready), 64'd0);
    check("bready_in_rsp", 64'(axi.b_ready), 64'd0);
    check("rready_in_rsp", 64'(axi.r_ready), 64'd0);
    if (rsp_dly >= 0) begin
      for (int i = 0; i < rsp_dly; i++) begin
        tick();
        check("rsp_hold_valid", 64'(rsp_valid), 64'd1);
        check("rsp_hold_rdata", rsp_rdata, exp_rdata);
        check("rsp_hold_err", 64'(rsp_err), 64'(exp_err));
      end
      rsp_ready = 1'b1;
    end
    tick();
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    check("req_ready_after_rsp", 64'(req_ready), 64'd1);
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [63:0] wd, input logic [7:0] ws,
                           input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] bresp, input logic [3:0] bid,
                           input int rsp_dly, input bit spur);
    int k, mx, exp_k;
    bit aw_seen, w_seen, b_seen, rsp_seen, aw_hs, w_hs, b_hs;
    logic exp_err;
    mx      = (aw_dly > w_dly) ? aw_dly : w_dly;
    exp_k   = 2 + mx + b_dly;
    exp_err = bresp[1] || (bid != 4'(TXN));
    aw_seen = 0; w_seen = 0; b_seen = 0; rsp_seen = 0;
    rsp_ready = (rsp_dly < 0);
    issue(1'b1, addr, wd, ws);
    check("aw_valid_rise", 64'(axi.aw_valid), 64'd1);
    check("w_valid_rise", 64'(axi.w_valid), 64'd1);
    check("ar_valid_idle", 64'(axi.ar_valid), 64'd0);
    check("aw_addr", 64'(axi.aw_addr), 64'(addr));
    check("aw_id", 64'(axi.aw_id), 64'(TXN));
    check("aw_len", 64'(axi.aw_len), 64'd0);
    check("aw_size", 64'(axi.aw_size), 64'd3);
    check("aw_burst", 64'(axi.aw_burst), 64'd1);
    check("aw_misc", 64'({axi.aw_lock, axi.aw_cache, axi.aw_prot, axi.aw_region, axi.aw_qos, axi.aw_user}), 64'd0);
    check("w_data", axi.w_data, wd);
    check("w_strb", 64'(axi.w_strb), 64'(ws));
    check("w_last", 64'(axi.w_last), 64'd1);
    check("w_user", 64'(axi.w_user), 64'd0);
    for (k = 0; k < 60; k++) begin
      if (rsp_valid === 1'b1) begin
        rsp_seen = 1;
        break;
      end
      if (aw_hs) check("aw_valid_drop", 64'(axi.aw_valid), 64'd0);
      if (w_hs)  check("w_valid_drop", 64'(axi.w_valid), 64'd0);
      if (spur)  check("rready_spurious", 64'(axi.r_ready), 64'd0);
      axi.aw_ready = (k >= aw_dly);
      axi.w_ready  = (k >= w_dly);
      axi.b_valid  = !b_seen && (k >= 1 + mx + b_dly);
      axi.b_resp   = bresp;
      axi.b_id     = bid;
      axi.r_valid  = spur;
      axi.r_last   = 1'b1;
      axi.r_data   = {$urandom, $urandom};
      aw_hs = axi.aw_valid && axi.aw_ready;
      w_hs  = axi.w_valid && axi.w_ready;
      b_hs  = axi.b_valid && axi.b_ready;
      tick();
      if (aw_hs) aw_seen = 1;
      if (w_hs)  w_seen = 1;
      if (b_hs)  b_seen = 1;
    end
    slave_idle();
    check("wr_rsp_timeout", 64'(rsp_seen), 64'd1);
    if (rsp_seen) finish_rsp(k, exp_k, 64'd0, exp_err, rsp_dly);
    rsp_ready = 1'b0;
  endtask

  task automatic run_read(input logic [31:0] addr, input int ar_dly, input int r_dly, input int nb,
                          input logic [1:0] rresp, input logic [3:0] rid,
                          input int rsp_dly, input bit spur);
    int k, beat, exp_k;
    bit ar_seen, ar_hs, r_hs, rsp_seen;
    logic exp_err;
    exp_k   = 2 + ar_dly + r_dly + nb - 1;
    exp_err = rresp[1] || (rid != 4'(TXN)) || (nb > 1);
    beat = 0; ar_seen = 0; ar_hs = 0; rsp_seen = 0;
    rsp_ready = (rsp_dly < 0);
    issue(1'b0, addr, {$urandom, $urandom}, 8'($urandom));
    check("ar_valid_rise", 64'(axi.ar_valid), 64'd1);
    check("aw_valid_idle", 64'(axi.aw_valid), 64'd0);
    check("w_valid_idle", 64'(axi.w_valid), 64'd0);
    check("rready_before_ar", 64'(axi.r_ready), 64'd0);
    check("ar_addr", 64'(axi.ar_addr), 64'(addr));
    check("ar_id", 64'(axi.ar_id), 64'(TXN));
    check("ar_len", 64'(axi.ar_len), 64'd0);
    check("ar_size", 64'(axi.ar_size), 64'd3);
    check("ar_burst", 64'(axi.ar_burst), 64'd1);
    for (k = 0; k < 60; k++) begin
      if (rsp_valid === 1'b1) begin
        rsp_seen = 1;
        break;
      end
      if (ar_hs) check("ar_valid_drop", 64'(axi.ar_valid), 64'd0);
      if (spur)  check("bready_spurious", 64'(axi.b_ready), 64'd0);
      axi.ar_ready = (k >= ar_dly);
      axi.b_valid  = spur;
      if (beat < nb && k >= 1 + ar_dly + r_dly) begin
        axi.r_valid = 1'b1;
        axi.r_data  = beat_data[beat];
        axi.r_last  = (beat == nb - 1);
        axi.r_resp  = (beat == 0) ? rresp : 2'b00;
        axi.r_id    = (beat == 0) ? rid : 4'(TXN);
      end else begin
        axi.r_valid = 1'b0;
      end
      ar_hs = axi.ar_valid && axi.ar_ready;
      r_hs  = axi.r_valid && axi.r_ready;
      tick();
      if (ar_hs) ar_seen = 1;
      if (r_hs)  beat++;
    end
    slave_idle();
    check("rd_ar_done", 64'(ar_seen), 64'd1);
    check("rd_beats", 64'(beat), 64'(nb));
    check("rd_rsp_timeout", 64'(rsp_seen), 64'd1);
    if (rsp_seen) finish_rsp(k, exp_k, beat_data[0], exp_err, rsp_dly);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    rsp_ready = 1'b0;
    slave_idle();
    tick(); tick();
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}), 64'd0);
    rstn = 1'b1;
    #1;
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Always-ready write, then W accepted 3 cycles before AW.
    run_write(32'h1000_0040, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0, 0, 2'b00, 4'(TXN), 0, 0);
    run_write(32'h1000_0080, 64'h1111_2222_3333_4444, 8'h0F, 3, 0, 1, 2'b00, 4'(TXN), 0, 0);
    run_write(32'h1000_00C0, 64'h5555_6666_7777_8888, 8'hF0, 0, 2, 0, 2'b00, 4'(TXN), 1, 0);

    // Back-to-back reads.
    beat_data[0] = 64'h0123_4567_89AB_CDEF;
    run_read(32'h2000_0008, 0, 0, 1, 2'b00, 4'(TXN), 0, 0);
    beat_data[0] = 64'hCAFE_F00D_0000_0001;
    run_read(32'h2000_0010, 1, 2, 1, 2'b00, 4'(TXN), 0, 0);

    // Error responses.
    beat_data[0] = 64'hBAD0_BAD0_BAD0_BAD0;
    run_read(32'h3000_0000, 0, 0, 1, 2'b10, 4'(TXN), 0, 0);
    run_write(32'h3000_0008, 64'h1, 8'h01, 0, 0, 0, 2'b11, 4'(TXN), 0, 0);
    run_write(32'h3000_0010, 64'h2, 8'h02, 0, 0, 0, 2'b00, 4'(TXN + 1), 0, 0);

    // Two-beat read: first data kept, error flagged.
    beat_data[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    beat_data[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    run_read(32'h4000_0000, 0, 0, 2, 2'b00, 4'(TXN), 0, 0);

    // Long response hold, early rsp_ready, spurious B/R.
    run_write(32'h5000_0000, 64'h0F0F_0F0F_0F0F_0F0F, 8'hAA, 1, 1, 0, 2'b00, 4'(TXN), 5, 1);
    beat_data[0] = 64'h7777_0000_7777_0000;
    run_read(32'h5000_0008, 0, 1, 1, 2'b00, 4'(TXN), -1, 1);

    // Reset while AW/W are stalled.
    issue(1'b1, 32'h6000_0000, 64'h1234, 8'hFF);
    tick(); tick();
    check("midrst_aw_before", 64'(axi.aw_valid), 64'd1);
    check("midrst_w_before", 64'(axi.w_valid), 64'd1);
    rstn = 1'b0;
    tick();
    check("midrst_valids", 64'({axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}), 64'd0);
    check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("midrst_req_ready", 64'(req_ready), 64'd0);
    check("midrst_rsp_err", 64'(rsp_err), 64'd0);
    rstn = 1'b1;
    #1;
    check("midrst_req_ready_after", 64'(req_ready), 64'd1);
    beat_data[0] = 64'h0000_0000_DEAD_0001;
    run_read(32'h6000_0010, 0, 0, 1, 2'b00, 4'(TXN), 0, 0);

    // Randomized mix.
    for (int t = 0; t < 24; t++) begin
      logic [3:0] id;
      logic [1:0] resp;
      id   = ($urandom_range(3, 0) == 0) ? 4'(TXN + 1) : 4'(TXN);
      resp = 2'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        run_write($urandom, {$urandom, $urandom}, 8'($urandom),
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                  resp, id, int'($urandom_range(3, 0)) - 1, 1'($urandom));
      end else begin
        for (int b = 0; b < 4; b++) beat_data[b] = {$urandom, $urandom};
        run_read($urandom, int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                 int'($urandom_range(3, 1)), resp, id, int'($urandom_range(3, 0)) - 1, 1'($urandom));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
